// File: rtl/mccoy_instr_sequencer_if.sv
// Control, program-load and core-side signals of the McCoy instruction sequencer.
// master = test harness / core side, slave = sequencer.
`timescale 1ns/1ps
interface mccoy_instr_sequencer_if #(
  parameter int DEPTH = 16,
  parameter int IW    = 6,
  parameter int DW    = 6
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clear;
  logic          wr_en;
  logic [IW-1:0] wr_data;
  logic          start;
  logic          abort;
  logic [3:0]    loop_count;
  logic          core_reset;
  logic [IW-1:0] instr;
  logic [DW-1:0] core_result;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [CW-1:0] count;

  modport master (
    output clear, wr_en, wr_data, start, abort, loop_count, core_result,
    input  core_reset, instr, result, result_valid, busy, done, overflow, count
  );

  modport slave (
    input  clear, wr_en, wr_data, start, abort, loop_count, core_result,
    output core_reset, instr, result, result_valid, busy, done, overflow, count
  );
endinterface

// File: rtl/mccoy_instr_sequencer.sv
// Program buffer and instruction streamer for the McCoy accumulator core:
// loads a short program, pulses core reset, issues it (optionally repeated) and captures results.
`timescale 1ns/1ps
module mccoy_instr_sequencer #(
  parameter int            DEPTH      = 16,
  parameter int            IW         = 6,
  parameter int            DW         = 6,
  parameter logic [IW-1:0] IDLE_INSTR = 6'b000000
) (
  input logic                    clk,
  input logic                    reset,
  mccoy_instr_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, CORE_RST, RUN, DRAIN} state_t;

  state_t        state;
  logic [IW-1:0] mem [DEPTH];
  logic [CW-1:0] count;
  logic [AW-1:0] pc;
  logic [3:0]    loops;
  logic          drain_cnt;
  logic          issued_d1;
  logic          rv_q;
  logic          overflow_q;
  logic          core_reset_q;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] result_q;

  logic idle;
  logic load_ok;
  logic last_instr;

  assign idle       = (state == IDLE);
  assign load_ok    = idle && bus.wr_en && !bus.clear && (count < CW'(DEPTH));
  assign last_instr = ({1'b0, pc} == count - CW'(1));

  // NOTE: the program store has no reset; its contents only matter after a load,
  // and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (load_ok) mem[count[AW-1:0]] <= bus.wr_data;
  end

  // NOTE: all state below uses non-blocking assignments so every register sees
  // pre-edge values; the abort override at the end relies on last-NBA-wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      pc           <= '0;
      loops        <= '0;
      drain_cnt    <= 1'b0;
      issued_d1    <= 1'b0;
      rv_q         <= 1'b0;
      overflow_q   <= 1'b0;
      core_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
    end else begin
      done_q <= 1'b0;

      // Two-stage result pipeline: core_result is valid the cycle after issue.
      issued_d1 <= (state == RUN) && !bus.abort;
      rv_q      <= issued_d1 && !bus.abort;
      if (issued_d1 && !bus.abort) result_q <= bus.core_result;

      case (state)
        IDLE: begin
          if (bus.clear) begin
            count      <= '0;
            overflow_q <= 1'b0;
          end else if (bus.wr_en) begin
            if (count < CW'(DEPTH)) count      <= count + CW'(1);
            else                    overflow_q <= 1'b1;
          end
          // A same-cycle clear empties the program, so start is refused.
          if (bus.start && !bus.clear && count != '0) begin
            state        <= CORE_RST;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b1;
            loops        <= bus.loop_count;
            pc           <= '0;
          end
        end
        CORE_RST: begin
          core_reset_q <= 1'b0;
          state        <= RUN;
        end
        RUN: begin
          if (!last_instr) begin
            pc <= pc + AW'(1);
          end else if (loops != 4'd0) begin
            pc    <= '0;
            loops <= loops - 4'd1;
          end else begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (bus.abort && !idle) begin
        state        <= IDLE;
        core_reset_q <= 1'b0;
        busy_q       <= 1'b0;
        done_q       <= 1'b0;
      end
    end
  end

  assign bus.instr        = (state == RUN) ? mem[pc] : IDLE_INSTR;
  assign bus.core_reset   = core_reset_q;
  assign bus.result       = result_q;
  // A strobe already in the output register is masked in the abort cycle itself.
  assign bus.result_valid = rv_q && !bus.abort;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.overflow     = overflow_q;
  assign bus.count        = count;
endmodule
